// File: rtl/traffic_pkg.sv
// Shared phase encoding, light-word constants and phase-to-lights decode
// for the timed traffic-light controller.
package traffic_pkg;

  typedef enum logic [1:0] {
    RED       = 2'd0,
    RED_AMBER = 2'd1,
    GREEN     = 2'd2,
    AMBER     = 2'd3
  } phase_t;

  localparam logic [2:0] LIGHTS_RED   = 3'b100;
  localparam logic [2:0] LIGHTS_RA    = 3'b110;
  localparam logic [2:0] LIGHTS_GREEN = 3'b001;
  localparam logic [2:0] LIGHTS_AMBER = 3'b010;

  function automatic logic [2:0] phase_lights(input phase_t p);
    logic [2:0] l;
    case (p)
      RED:       l = LIGHTS_RED;
      RED_AMBER: l = LIGHTS_RA;
      GREEN:     l = LIGHTS_GREEN;
      AMBER:     l = LIGHTS_AMBER;
      default:   l = LIGHTS_RED;
    endcase
    return l;
  endfunction

endpackage

// File: rtl/traffic_lights_timed_phase_timer.sv
// Per-phase dwell counter: counts enabled cycles, flags the final dwell cycle,
// and restarts from zero when the phase is left.
module phase_timer #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             clear,
  input  logic [CNT_W:0]   limit,
  output logic [CNT_W-1:0] cnt,
  output logic             done
);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (enable) begin
      if (clear) cnt <= '0;
      else       cnt <= cnt + CNT_W'(1);
    end
  end

  // limit is one bit wider than cnt so a dwell of exactly 2^CNT_W is reachable
  assign done = enable && ({1'b0, cnt} == (limit - (CNT_W + 1)'(1)));

endmodule

// File: rtl/traffic_lights_timed.sv
// Timed UK-sequence traffic-light controller (RED, RED_AMBER, GREEN, AMBER).
// Define TRAFFIC_PED_REQ_EN to build in the pedestrian request / green cut.
module traffic_lights_timed
  import traffic_pkg::*;
#(
  parameter int unsigned RED_CYCLES   = 8,
  parameter int unsigned RA_CYCLES    = 2,
  parameter int unsigned GREEN_CYCLES = 8,
  parameter int unsigned AMBER_CYCLES = 3,
  parameter int unsigned GREEN_MIN    = 4,
  parameter int unsigned CNT_W        = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic       req,
  output logic [2:0] lights,
  output logic [1:0] phase,
  output logic       ped_wait
);

  localparam int unsigned LIM_W = CNT_W + 1;

  phase_t           state;
  phase_t           next_state;
  logic [CNT_W:0]   limit;
  logic [CNT_W-1:0] cnt;
  logic             done;
  logic             cut;
  logic             exit_phase;

  phase_timer #(.CNT_W(CNT_W)) u_timer (
    .clk    (clk),
    .rst    (rst),
    .enable (enable),
    .clear  (exit_phase),
    .limit  (limit),
    .cnt    (cnt),
    .done   (done)
  );

  // Dwell selection, early green exit and next-phase decode
  always_comb begin
    limit      = LIM_W'(RED_CYCLES);
    next_state = state;
    cut        = 1'b0;
    case (state)
      RED:       limit = LIM_W'(RED_CYCLES);
      RED_AMBER: limit = LIM_W'(RA_CYCLES);
      GREEN:     limit = LIM_W'(GREEN_CYCLES);
      AMBER:     limit = LIM_W'(AMBER_CYCLES);
      default:   limit = LIM_W'(RED_CYCLES);
    endcase
`ifdef TRAFFIC_PED_REQ_EN
    cut = (state == GREEN) && enable && ped_wait &&
          ({1'b0, cnt} >= LIM_W'(GREEN_MIN - 1));
`endif
    exit_phase = done || cut;
    if (exit_phase) begin
      case (state)
        RED:       next_state = RED_AMBER;
        RED_AMBER: next_state = GREEN;
        GREEN:     next_state = AMBER;
        AMBER:     next_state = RED;
        default:   next_state = RED;
      endcase
    end
  end

  // Outputs decode from the next state so they track the phase register exactly
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= RED;
      lights <= LIGHTS_RED;
      phase  <= 2'd0;
    end else begin
      state  <= next_state;
      lights <= phase_lights(next_state);
      phase  <= next_state;
    end
  end

`ifdef TRAFFIC_PED_REQ_EN
  // Request latch runs regardless of enable; a new request beats the clear
  always_ff @(posedge clk) begin
    if (rst)                                  ped_wait <= 1'b0;
    else if (req)                             ped_wait <= 1'b1;
    else if ((state == GREEN) && exit_phase)  ped_wait <= 1'b0;
  end
`else
  logic unused_cfg;
  assign unused_cfg = ^{req, cnt, LIM_W'(GREEN_MIN)};
  assign ped_wait   = 1'b0;
`endif

endmodule

// File: doc/traffic_lights_timed.md
# traffic_lights_timed

Timed UK-sequence traffic-light controller producing the 3-bit `{red, amber, green}` light word consumed by the display multiplexer's `b` input. A Moore FSM steps through four phases, and a per-phase dwell counter sets each phase length. An optional pedestrian request can cut the green phase short. The output is registered and changes only on `clk` edges.

## Interface
- `RED_CYCLES`, default 8: dwell of RED, in enabled cycles (≥1).
- `RA_CYCLES`, default 2: dwell of RED_AMBER (≥1).
- `GREEN_CYCLES`, default 8: full dwell of GREEN (≥1).
- `AMBER_CYCLES`, default 3: dwell of AMBER (≥1).
- `GREEN_MIN`, default 4: minimum GREEN dwell before a pedestrian cut (1 ≤ GREEN_MIN ≤ GREEN_CYCLES).
- `CNT_W`, default 8: dwell counter width. Every dwell parameter is ≤ 2^CNT_W.

Ports:
- `clk` in 1: single clock; all state changes on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `enable` in 1: advance the counter/FSM this cycle; low freezes all state.
- `req` in 1: pedestrian request, level sampled every cycle.
- `lights` out 3: `{red, amber, green}`, registered.
- `phase` out 2: current phase code.
- `ped_wait` out 1: pedestrian request pending.

## Operation
- Phases and light encodings:
  - RED = 2'd0, lights 3'b100
  - RED_AMBER = 2'd1, lights 3'b110
  - GREEN = 2'd2, lights 3'b001
  - AMBER = 2'd3, lights 3'b010
- Cycle order: RED → RED_AMBER → GREEN → AMBER → RED.
- Dwell counter `cnt` is cleared on every phase entry and increments on enabled cycles.
- A phase with dwell N exits on the enabled cycle where `cnt == N-1`.
- `lights` and `phase` are decoded into registers from the next state, so they always match the current phase with no glitches.
- When `enable` is low, `cnt`, the phase and the outputs hold their values. `ped_wait` still latches `req`.
- Pedestrian cut: in GREEN, an enabled cycle with `ped_wait` high and `cnt ≥ GREEN_MIN-1` exits to AMBER.
- `ped_wait` clears on the cycle GREEN exits, by either cut or expiry.
- If `req` is high in that same exit cycle, the set wins and `ped_wait` stays high for the next cycle.
- `req` arriving during RED, RED_AMBER or AMBER sets `ped_wait`. That request is served in the next GREEN at `GREEN_MIN`.

## Timing
- Reset values: phase RED, `cnt` 0, `lights` 3'b100, `phase` 2'd0, `ped_wait` 0.
- Reset takes priority over `enable` and `req`.
- A reset asserted mid-phase returns to RED on the next edge with `cnt` 0.
- Phase transitions occur on the edge after the final enabled dwell cycle, so outputs update with zero added latency relative to the state.
- With `enable` held high, one full cycle is RED + RA + GREEN + AMBER cycles (21 with the defaults).
- `req` → `ped_wait` high: 1 cycle.
- Earliest cut: GREEN lasts exactly `GREEN_MIN` enabled cycles.
- The counter saturates in no case; it is always cleared at the phase exit.

## Configuration
- `TRAFFIC_PED_REQ_EN` defined: pedestrian-cut logic and the `ped_wait` register are present, as described above.
- `TRAFFIC_PED_REQ_EN` undefined:
  - `req` is ignored.
  - `ped_wait` is tied to 0.
  - GREEN always runs `GREEN_CYCLES`.
  - `GREEN_MIN` is unused.
- Ports are identical in both builds.

## Structure
- Package `traffic_pkg` holds:
  - the phase typedef (2-bit enum RED/RED_AMBER/GREEN/AMBER);
  - the light-word constants `LIGHTS_RED` = 3'b100, `LIGHTS_RA` = 3'b110, `LIGHTS_GREEN` = 3'b001, `LIGHTS_AMBER` = 3'b010;
  - the phase-to-lights decode function.
- One natural sub-module, `phase_timer`, holds the `CNT_W`-bit counter.
  - Inputs: `clk`, `rst`, `enable`, `clear`, `limit`.
  - Outputs: `cnt`, `done` (`cnt == limit-1` and `enable`).
- The FSM, request latch and output registers live in `traffic_lights_timed`.

## Test plan
- Reset: hold `rst` 3 cycles with `enable`=1 and `req`=1 → `lights`=3'b100, `phase`=0, `ped_wait`=0 throughout.
- Free run with defaults, `enable`=1: `lights` shows 100 ×8, then 110 ×2, then 001 ×8, then 010 ×3, then 100, repeating every 21 cycles.
- `enable` toggled 1-0-1-0: each phase lasts 2× its nominal dwell in wall-clock cycles, and the output never changes on an `enable`=0 cycle.
- Pedestrian request (feature built in): `req` pulse at GREEN `cnt`=1 → `ped_wait` high next cycle; GREEN lasts 4 cycles, then AMBER; `ped_wait` clears on the AMBER entry.
- `req` held during the GREEN→AMBER exit cycle → `ped_wait` stays 1; the next GREEN is cut at 4 cycles. Without `TRAFFIC_PED_REQ_EN`, the same stimulus gives GREEN = 8 cycles and `ped_wait` = 0.
- Reset mid-GREEN at `cnt`=5 → next cycle RED, `cnt` 0, `lights` 3'b100; the full RED dwell of 8 cycles follows.
